// File: rtl/adder_pkg.sv
// Shared definitions for the carry-pipelined adder/subtractor.
package adder_pkg;

   // Bits added per pipeline stage; a zero stage count falls back to one chunk.
   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   // Per-stage control payload; the width-dependent operand/sum fields live in the top.
   typedef struct packed {
      logic valid;
      logic sub;
      logic carry;
      logic ovf;
   } stage_ctrl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational C-bit ripple-carry adder built from full-adder cells.
module adder_chunk #(
   parameter int unsigned C = 8
) (
   input  logic [C-1:0] a,
   input  logic [C-1:0] b,
   input  logic         cin,
   output logic [C-1:0] sum,
   output logic         cout,
   output logic         c_msb_in
);

   logic [C:0] c;

   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < C; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[C];
   assign c_msb_in = c[C-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract split into STAGES carry-pipelined chunks with
// valid/ready handshake on both ends; one chunk is resolved per cycle.
module pipelined_add_sub
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned C = chunk_width(WIDTH, STAGES);

   if (STAGES < 1) begin : g_bad_stages
      $error("pipelined_add_sub: STAGES must be at least 1");
   end else if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
   end

   // word_q: finished sum chunks below, untouched A chunks above.
   // bop_q : B (already inverted for subtract) riding along for upper chunks.
   stage_ctrl_t      ctrl_q   [STAGES];
   logic [WIDTH-1:0] word_q   [STAGES];
   logic [WIDTH-1:0] bop_q    [STAGES];
   stage_ctrl_t      ctrl_nxt [STAGES];
   logic [WIDTH-1:0] word_nxt [STAGES];
   logic [WIDTH-1:0] bop_nxt  [STAGES];

   logic advance;

   // Whole pipeline moves together; it only stalls when the output is held.
   assign advance  = !ctrl_q[STAGES-1].valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] CMASK = WIDTH'({C{1'b1}}) << (k * C);

      logic [WIDTH-1:0] a_w;
      logic [WIDTH-1:0] b_w;
      logic             v_in;
      logic             sub_in;
      logic             ci;
      logic [C-1:0]     s_c;
      logic             co;
      logic             cm;

      if (k == 0) begin : g_head
         assign a_w    = A;
         assign b_w    = B ^ {WIDTH{sub}};
         assign ci     = sub | Cin;
         assign v_in   = in_valid;
         assign sub_in = sub;
      end else begin : g_body
         assign a_w    = word_q[k-1];
         assign b_w    = bop_q[k-1];
         assign ci     = ctrl_q[k-1].carry;
         assign v_in   = ctrl_q[k-1].valid;
         assign sub_in = ctrl_q[k-1].sub;
      end

      adder_chunk #(.C(C)) u_chunk (
         .a        (a_w[k*C +: C]),
         .b        (b_w[k*C +: C]),
         .cin      (ci),
         .sum      (s_c),
         .cout     (co),
         .c_msb_in (cm)
      );

      assign word_nxt[k] = (a_w & ~CMASK) | (WIDTH'(s_c) << (k * C));
      assign bop_nxt[k]  = b_w;
      assign ctrl_nxt[k] = '{valid: v_in, sub: sub_in, carry: co, ovf: co ^ cm};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            word_q[k] <= '0;
            bop_q[k]  <= '0;
         end
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= ctrl_nxt[k];
            word_q[k] <= word_nxt[k];
            bop_q[k]  <= bop_nxt[k];
         end
      end
   end

   assign out_valid = ctrl_q[STAGES-1].valid;
   assign Sum       = word_q[STAGES-1];
   assign Cout      = ctrl_q[STAGES-1].carry;
   assign Ovf       = ctrl_q[STAGES-1].ovf;

   // The last stage's B copy and mode bit have no consumer.
   logic unused_tail;
   assign unused_tail = ^{bop_q[STAGES-1], ctrl_q[STAGES-1].sub};

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and streaming checks of pipelined_add_sub at STAGES = 4, 1 and 8.
module tb_pipelined_add_sub;

   localparam int unsigned W     = 32;
   localparam int unsigned N_DUT = 3;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         sub;
   logic         out_ready;

   logic         ir [N_DUT];
   logic         ov [N_DUT];
   logic [W-1:0] sm [N_DUT];
   logic         co [N_DUT];
   logic         of [N_DUT];

   int n_vec = 0;
   int n_bad = 0;

   pipelined_add_sub #(.WIDTH(W), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .A(A), .B(B), .Cin(Cin), .sub(sub),
      .out_valid(ov[0]), .out_ready(out_ready),
      .Sum(sm[0]), .Cout(co[0]), .Ovf(of[0])
   );

   pipelined_add_sub #(.WIDTH(W), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .A(A), .B(B), .Cin(Cin), .sub(sub),
      .out_valid(ov[1]), .out_ready(out_ready),
      .Sum(sm[1]), .Cout(co[1]), .Ovf(of[1])
   );

   pipelined_add_sub #(.WIDTH(W), .STAGES(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .A(A), .B(B), .Cin(Cin), .sub(sub),
      .out_valid(ov[2]), .out_ready(out_ready),
      .Sum(sm[2]), .Cout(co[2]), .Ovf(of[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {cout, ovf, sum} from plain 33-bit arithmetic.
   function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic s);
      logic [W-1:0] bx;
      logic [W:0]   full;
      bx   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bx} + 33'(s ? 1'b1 : cin);
      return {full[W], (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]), full[W-1:0]};
   endfunction

   // One beat into all three builds; check each at its own latency.
   task automatic run_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic s, input logic [W-1:0] e_sum,
                           input logic e_cout, input logic e_ovf);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      A = a; B = b; Cin = cin; sub = s;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            in_valid = 1'b0;
            A        = $urandom;
            B        = $urandom;
            Cin      = ~Cin;
            sub      = ~sub;
         end
         for (int i = 0; i < N_DUT; i++) begin
            if (n == lat_of(i)) begin
               check_eq($sformatf("%s S%0d out_valid", tag, lat_of(i)), 64'(ov[i]), 64'd1);
               check_eq($sformatf("%s S%0d Sum", tag, lat_of(i)), 64'(sm[i]), 64'(e_sum));
               check_eq($sformatf("%s S%0d Cout", tag, lat_of(i)), 64'(co[i]), 64'(e_cout));
               check_eq($sformatf("%s S%0d Ovf", tag, lat_of(i)), 64'(of[i]), 64'(e_ovf));
            end else if (n + 1 == lat_of(i)) begin
               check_eq($sformatf("%s S%0d early valid", tag, lat_of(i)), 64'(ov[i]), 64'd0);
            end
         end
      end
   endtask

   // 16 random beats with random backpressure on the STAGES=4 build.
   task automatic stream_test();
      logic [33:0] q[$];
      logic [33:0] exp_r;
      int          sent;
      int          got;
      logic        fire_in;
      logic        fire_out;
      logic        last_fire;
      sent      = 0;
      got       = 0;
      last_fire = 1'b0;
      in_valid  = 1'b0;
      for (int cyc = 0; cyc < 600 && got < 16; cyc++) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid || last_fire) begin
            if (sent < 16) begin
               in_valid = 1'b1;
               A        = $urandom;
               B        = $urandom;
               Cin      = 1'($urandom_range(0, 1));
               sub      = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
         #1;
         check_eq("stream in_ready", 64'(ir[0]), 64'(!(ov[0] && !out_ready)));
         fire_in  = in_valid && ir[0];
         fire_out = ov[0] && out_ready;
         if (fire_out) begin
            check_eq("stream result expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               exp_r = q.pop_front();
               check_eq($sformatf("stream beat %0d", got), 64'({co[0], of[0], sm[0]}), 64'(exp_r));
            end
            got++;
         end
         if (fire_in) begin
            q.push_back(model(A, B, Cin, sub));
            sent++;
         end
         last_fire = fire_in;
      end
      check_eq("stream results received", 64'(got), 64'd16);
      check_eq("stream beats left over", 64'(q.size()), 64'd0);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1);
   end

   initial begin
      logic stale [N_DUT];
      rst       = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         check_eq($sformatf("reset S%0d out_valid", lat_of(i)), 64'(ov[i]), 64'd0);
         check_eq($sformatf("reset S%0d Sum", lat_of(i)), 64'(sm[i]), 64'd0);
         check_eq($sformatf("reset S%0d Cout", lat_of(i)), 64'(co[i]), 64'd0);
         check_eq($sformatf("reset S%0d Ovf", lat_of(i)), 64'(of[i]), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_DUT; i++)
         check_eq($sformatf("post-reset S%0d in_ready", lat_of(i)), 64'(ir[i]), 64'd1);

      run_beat("carry0to1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      run_beat("ripple_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_beat("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_beat("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_beat("sub_cin_ign", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
      run_beat("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      stream_test();

      // Three beats in flight, then reset.
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         in_valid = 1'b1;
         A        = 32'h1000_0000 + 32'(j);
         B        = 32'h0000_0100;
         Cin      = 1'b0;
         sub      = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("pre-reset S1 out_valid", 64'(ov[1]), 64'd1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         check_eq($sformatf("mid-reset S%0d out_valid", lat_of(i)), 64'(ov[i]), 64'd0);
         check_eq($sformatf("mid-reset S%0d Sum", lat_of(i)), 64'(sm[i]), 64'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N_DUT; i++) stale[i] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N_DUT; i++) stale[i] = stale[i] | ov[i];
      end
      for (int i = 0; i < N_DUT; i++)
         check_eq($sformatf("stale after reset S%0d", lat_of(i)), 64'(stale[i]), 64'd0);

      run_beat("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
